// File: rtl/hilo_muldiv_ctrl_pkg.sv
// hilo_pkg: shared encodings for the HI/LO multiply/divide sequencer.
// Holds the op encodings, the controller state encoding and the default
// operand width / iteration count.
package hilo_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int ITER       = DATA_WIDTH;

   typedef enum logic [1:0] {
      OP_MULTU = 2'b00,
      OP_MULT  = 2'b01,
      OP_DIVU  = 2'b10,
      OP_DIV   = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_e;

   // Bit 1 of the op selects divide, bit 0 selects signed.
   function automatic logic op_is_div(input logic [1:0] op);
      return op[1];
   endfunction

   function automatic logic op_is_signed(input logic [1:0] op);
      return op[0];
   endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_if.sv
// hilo_if: execute-stage <-> HI/LO sequencer signal bundle.
// master = pipeline side (issues ops, MTHI/MTLO, MFHI/MFLO reads),
// slave  = the sequencer that owns HI/LO.
interface hilo_if
   import hilo_pkg::*;
#(
   parameter int data_width = DATA_WIDTH
);
   logic                  start;
   logic [1:0]            op;
   logic [data_width-1:0] rs_data;
   logic [data_width-1:0] rt_data;
   logic                  mthi;
   logic                  mtlo;
   logic [data_width-1:0] wr_data;
   logic                  read_hilo;
   logic [data_width-1:0] hi_reg;
   logic [data_width-1:0] lo_reg;
   logic                  busy;
   logic                  stall;
   logic                  done;

   modport master (
      output start, op, rs_data, rt_data, mthi, mtlo, wr_data, read_hilo,
      input  hi_reg, lo_reg, busy, stall, done
   );

   modport slave (
      input  start, op, rs_data, rt_data, mthi, mtlo, wr_data, read_hilo,
      output hi_reg, lo_reg, busy, stall, done
   );
endinterface

// File: rtl/hilo_muldiv_ctrl_muldiv_iter_core.sv
// muldiv_iter_core: datapath for one-bit-per-cycle shift-add multiply and
// restoring divide on unsigned magnitudes.
//   multiply: {r_hi,r_lo} starts as {0, multiplier}, r_opnd = multiplicand;
//             after data_width steps {r_hi,r_lo} is the 2*data_width product.
//   divide:   {r_hi,r_lo} starts as {0, dividend},   r_opnd = divisor;
//             after data_width steps r_hi = remainder, r_lo = quotient.
module muldiv_iter_core
   import hilo_pkg::*;
#(
   parameter int data_width = ITER
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_load,
   input  logic                  i_step,
   input  logic                  i_is_div,
   input  logic [data_width-1:0] i_lo_init,
   input  logic [data_width-1:0] i_opnd_init,
   output logic [data_width-1:0] o_hi,
   output logic [data_width-1:0] o_lo,
   output logic [data_width-1:0] o_opnd
);

   logic [data_width-1:0] r_hi;
   logic [data_width-1:0] r_lo;
   logic [data_width-1:0] r_opnd;

   logic [data_width:0]   w_mul_sum;
   logic [data_width:0]   w_div_shift;
   logic [data_width-1:0] w_div_diff;
   logic                  w_div_ge;
   logic [data_width-1:0] w_next_hi;
   logic [data_width-1:0] w_next_lo;

   // Next accumulator value for a single multiply or divide iteration.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
      w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
      w_div_shift = {r_hi, r_lo[data_width-1]};
      w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
      // Remainder stays below the divisor, so the low bits hold the full difference.
      w_div_diff  = w_div_shift[data_width-1:0] - r_opnd;
      w_next_hi   = w_mul_sum[data_width:1];
      w_next_lo   = {w_mul_sum[0], r_lo[data_width-1:1]};
      if (i_is_div) begin
         w_next_hi = w_div_ge ? w_div_diff : w_div_shift[data_width-1:0];
         w_next_lo = {r_lo[data_width-2:0], w_div_ge};
      end
   end

   // Load operands on issue, then advance one iteration per step.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register here sees the pre-edge values of the others.
      if (rst) begin
         r_hi   <= '0;
         r_lo   <= '0;
         r_opnd <= '0;
      end else if (i_load) begin
         r_hi   <= '0;
         r_lo   <= i_lo_init;
         r_opnd <= i_opnd_init;
      end else if (i_step) begin
         r_hi   <= w_next_hi;
         r_lo   <= w_next_lo;
      end
   end

   assign o_hi   = r_hi;
   assign o_lo   = r_lo;
   assign o_opnd = r_opnd;

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: HI/LO owner and multiply/divide sequencer.
// IDLE -> CALC (data_width iterations) -> FIX (sign fixup, HI/LO write,
// done pulse) -> IDLE. MTHI/MTLO act only in IDLE; any request arriving
// while busy is stalled and must be re-presented.
// Build option: define HILO_FAST_MUL_EN to replace the iterative multiply
// with a single-cycle array multiply (multiply ops go IDLE -> FIX).
module hilo_muldiv_ctrl
   import hilo_pkg::*;
#(
   parameter int data_width = ITER
)
(
   input  logic clk,
   input  logic rst,
   hilo_if.slave bus
);

   localparam int CNT_W = $clog2(data_width);

   state_e                  r_state;
   logic [CNT_W-1:0]        r_count;
   logic                    r_is_div;
   logic                    r_neg_res;
   logic                    r_neg_rem;
   logic                    r_div_zero;
   logic                    r_done;
   logic [data_width-1:0]   r_rs_raw;
   logic [data_width-1:0]   r_hi;
   logic [data_width-1:0]   r_lo;

   logic                    w_issue;
   logic                    w_busy;
   logic                    w_op_div;
   logic                    w_rs_neg;
   logic                    w_rt_neg;
   logic                    w_skip_calc;
   logic [data_width-1:0]   w_rs_mag;
   logic [data_width-1:0]   w_rt_mag;
   logic [data_width-1:0]   w_core_hi;
   logic [data_width-1:0]   w_core_lo;
   logic [data_width-1:0]   w_core_opnd;
   logic [2*data_width-1:0] w_prod;
   logic [2*data_width-1:0] w_prod_fix;
   logic [data_width-1:0]   w_fix_hi;
   logic [data_width-1:0]   w_fix_lo;

   assign w_issue  = (r_state == IDLE) && bus.start;
   assign w_busy   = (r_state != IDLE);
   assign w_op_div = op_is_div(bus.op);
   assign w_rs_neg = op_is_signed(bus.op) & bus.rs_data[data_width-1];
   assign w_rt_neg = op_is_signed(bus.op) & bus.rt_data[data_width-1];
   assign w_rs_mag = w_rs_neg ? -bus.rs_data : bus.rs_data;
   assign w_rt_mag = w_rt_neg ? -bus.rt_data : bus.rt_data;

`ifdef HILO_FAST_MUL_EN
   assign w_skip_calc = ~w_op_div;
   assign w_prod      = {{data_width{1'b0}}, w_core_lo} * {{data_width{1'b0}}, w_core_opnd};
`else
   assign w_skip_calc = 1'b0;
   assign w_prod      = {w_core_hi, w_core_lo};
`endif

   muldiv_iter_core #(
      .data_width (data_width)
   ) u_core (
      .clk         (clk),
      .rst         (rst),
      .i_load      (w_issue),
      .i_step      (r_state == CALC),
      .i_is_div    (r_is_div),
      .i_lo_init   (w_op_div ? w_rs_mag : w_rt_mag),
      .i_opnd_init (w_op_div ? w_rt_mag : w_rs_mag),
      .o_hi        (w_core_hi),
      .o_lo        (w_core_lo),
      .o_opnd      (w_core_opnd)
   );

   // Sign fixup and divide-by-zero override of the raw datapath result.
   always_comb begin
      w_prod_fix = r_neg_res ? -w_prod : w_prod;
      w_fix_hi   = w_prod_fix[2*data_width-1:data_width];
      w_fix_lo   = w_prod_fix[data_width-1:0];
      if (r_is_div) begin
         if (r_div_zero) begin
            w_fix_hi = r_rs_raw;
            w_fix_lo = '1;
         end else begin
            w_fix_hi = r_neg_rem ? -w_core_hi : w_core_hi;
            w_fix_lo = r_neg_res ? -w_core_lo : w_core_lo;
         end
      end
   end

   // Sequencer FSM, iteration count, HI/LO ownership and done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_count    <= '0;
         r_is_div   <= 1'b0;
         r_neg_res  <= 1'b0;
         r_neg_rem  <= 1'b0;
         r_div_zero <= 1'b0;
         r_rs_raw   <= '0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_is_div   <= w_op_div;
                  r_neg_res  <= w_rs_neg ^ w_rt_neg;
                  r_neg_rem  <= w_rs_neg;
                  r_div_zero <= (bus.rt_data == '0);
                  r_rs_raw   <= bus.rs_data;
                  r_count    <= '0;
                  if (w_skip_calc) begin
                     r_state <= FIX;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= CALC;
                  end
               end else begin
                  if (bus.mthi) r_hi <= bus.wr_data;
                  if (bus.mtlo) r_lo <= bus.wr_data;
               end
            end
            CALC: begin
               if (r_count == CNT_W'(data_width - 1)) begin
                  r_state <= FIX;
                  r_done  <= 1'b1;
               end else begin
                  r_count <= r_count + 1'b1;
               end
            end
            FIX: begin
               r_hi    <= w_fix_hi;
               r_lo    <= w_fix_lo;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.hi_reg = r_hi;
   assign bus.lo_reg = r_lo;
   assign bus.busy   = w_busy;
   assign bus.stall  = w_busy & (bus.read_hilo | bus.start | bus.mthi | bus.mtlo);
   assign bus.done   = r_done;

endmodule
